// File: rtl/display_pkg.sv
// Shared display constants and helpers.
// Used by the BCD converter and its digit adjusters.
package display_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits needed to show 2^width-1.
  function automatic int bcd_digits_for(input int width);
    longint unsigned v;
    int d;
    if (width >= 64) v = '1;
    else v = (64'd1 << width) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data
// bundle of the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction:
// add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= BCD_ADJ_THRESH)
               ? d_in + BCD_ADJ_ADD
               : d_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed
// BCD converter, one input bit per cycle.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clock,
  input  logic             resetn,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("bin_to_bcd_seq: WIDTH must be >= 1");
    end else if (DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [BW-1:0]    acc, acc_n;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt, cnt_n;
  logic [BW-1:0]    bcd_q, bcd_n;
  logic             done_q, done_n;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_in  (acc[4*g +: 4]),
      .d_out (adj[4*g +: 4])
    );
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      bcd_q  <= bcd_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    acc_n   = acc;
    cnt_n   = cnt;
    bcd_n   = bcd_q;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          sh_n    = bus.bin_in;
          acc_n   = '0;
          cnt_n   = CW'(WIDTH);
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Adjusted digits shift up; MSB of sh enters the units digit.
        acc_n = {adj[BW-2:0], sh[WIDTH-1]};
        sh_n  = sh << 1;
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          bcd_n   = acc_n;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  assign bus.busy    = (state == ST_SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed checks of the sequential BCD
// converter at 8 and 16 bit widths.
module tb_bin_to_bcd_seq;

  logic clock;
  logic resetn;

  int n_chk;
  int n_fail;
  int pulses;

  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) b8  ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b16 ();

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (b8)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (b16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [7:0]  v,
                          input logic [11:0] exp,
                          input string       tag);
    int busy_cnt;
    int early;
    @(negedge clock);
    b8.start  = 1'b1;
    b8.bin_in = v;
    @(posedge clock);
    #1;
    b8.start = 1'b0;
    busy_cnt = 0;
    early    = 0;
    if (b8.busy) busy_cnt++;
    if (b8.done) early++;
    for (int i = 1; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (b8.busy) busy_cnt++;
      if (b8.done) early++;
    end
    @(posedge clock);
    #1;
    chk({tag, " done"}, 32'(b8.done), 32'd1);
    chk({tag, " bcd"}, 32'(b8.bcd_out), 32'(exp));
    chk({tag, " busy_end"}, 32'(b8.busy), 32'd0);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, " early_done"}, 32'(early), 32'd0);
    @(posedge clock);
    #1;
    chk({tag, " done_drop"}, 32'(b8.done), 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    resetn     = 1'b0;
    b8.start   = 1'b0;
    b8.bin_in  = '0;
    b16.start  = 1'b0;
    b16.bin_in = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst busy", 32'(b8.busy), 32'd0);
    chk("rst done", 32'(b8.done), 32'd0);
    chk("rst bcd", 32'(b8.bcd_out), 32'd0);
    chk("rst bcd16", 32'(b16.bcd_out), 32'd0);
    resetn = 1'b1;

    run_conv(8'd0,   12'h000, "zero");
    run_conv(8'd255, 12'h255, "max");
    run_conv(8'd128, 12'h128, "v128");
    run_conv(8'd99,  12'h099, "v99");

    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v),
               {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)},
               "sweep");
    end

    // start held high: back-to-back conversions
    @(negedge clock);
    b8.start  = 1'b1;
    b8.bin_in = 8'd7;
    @(posedge clock);
    #1;
    b8.bin_in = 8'd42;
    pulses = 0;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clock);
      #1;
      if (b8.done) pulses++;
      if (c == 8) begin
        chk("b2b done0", 32'(b8.done), 32'd1);
        chk("b2b bcd0", 32'(b8.bcd_out), 32'h007);
      end
      if (c == 9) b8.bin_in = 8'd200;
      if (c == 17) begin
        chk("b2b done1", 32'(b8.done), 32'd1);
        chk("b2b bcd1", 32'(b8.bcd_out), 32'h042);
      end
      if (c == 18) b8.start = 1'b0;
      if (c == 26) begin
        chk("b2b done2", 32'(b8.done), 32'd1);
        chk("b2b bcd2", 32'(b8.bcd_out), 32'h200);
      end
    end
    chk("b2b pulses", 32'(pulses), 32'd3);

    // start during SHIFT is ignored
    @(negedge clock);
    b8.start  = 1'b1;
    b8.bin_in = 8'd37;
    @(posedge clock);
    #1;
    b8.start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      #1;
      if (b8.done) pulses++;
      if (c == 3) begin
        b8.start  = 1'b1;
        b8.bin_in = 8'd250;
      end
      if (c == 4) b8.start = 1'b0;
      if (c == 8) begin
        chk("ign done", 32'(b8.done), 32'd1);
        chk("ign bcd", 32'(b8.bcd_out), 32'h037);
      end
    end
    chk("ign pulses", 32'(pulses), 32'd1);
    chk("ign bcd_hold", 32'(b8.bcd_out), 32'h037);
    chk("ign idle", 32'(b8.busy), 32'd0);

    // reset in the 4th SHIFT cycle
    @(negedge clock);
    b8.start  = 1'b1;
    b8.bin_in = 8'd123;
    @(posedge clock);
    #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("abort busy_pre", 32'(b8.busy), 32'd1);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    chk("abort busy", 32'(b8.busy), 32'd0);
    chk("abort done", 32'(b8.done), 32'd0);
    chk("abort bcd", 32'(b8.bcd_out), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
      if (b8.done) pulses++;
    end
    chk("abort no_done", 32'(pulses), 32'd0);
    run_conv(8'd61, 12'h061, "post_rst");

    // 16-bit instance
    @(negedge clock);
    b16.start  = 1'b1;
    b16.bin_in = 16'd65535;
    @(posedge clock);
    #1;
    b16.start = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    chk("w16 busy_pre", 32'(b16.busy), 32'd1);
    chk("w16 done_pre", 32'(b16.done), 32'd0);
    @(posedge clock);
    #1;
    chk("w16 done", 32'(b16.done), 32'd1);
    chk("w16 bcd", 32'(b16.bcd_out), 32'h65535);

    @(negedge clock);
    b16.start  = 1'b1;
    b16.bin_in = 16'd12345;
    @(posedge clock);
    #1;
    b16.start = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    chk("w16b done", 32'(b16.done), 32'd1);
    chk("w16b bcd", 32'(b16.bcd_out), 32'h12345);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential shift-add-3 (double-dabble) converter turning an unsigned binary value into packed BCD digits for the board's decimal displays. It sits directly upstream of the `seven_segments` hex-digit decoders: each 4-bit nibble of `bcd_out` drives one decoder's `data_in`. A conversion takes one cycle per input bit and is controlled by a start/busy/done handshake, so I/O-port logic can convert a register value without a wide combinational divider.

## Interface
- `WIDTH`, default 8: binary input width, in bits; must be ≥ 1.
- `DIGITS`, default 3: number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH−1. An elaboration-time check fails the build otherwise.
- `clock` in 1: single clock. All state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: request a conversion. Sampled only in IDLE.
- `bin_in` in WIDTH: unsigned value. Captured on the edge that accepts `start`.
- `busy` out 1: high while a conversion is in progress (state SHIFT).
- `done` out 1: one-cycle pulse when `bcd_out` has just been updated.
- `bcd_out` out 4*DIGITS: packed BCD. Digit 0 (units) is in [3:0]; digit k is in [4k+3:4k]. Holds its value until the next completion.

## Operation
- Registers:
  - binary shift register `sh` (WIDTH bits).
  - BCD scratch register `acc` (4*DIGITS bits).
  - bit counter `cnt` (⌈log2(WIDTH+1)⌉ bits).
  - state register, plus the `bcd_out` and `done` registers.
- States: IDLE, SHIFT.
- IDLE:
  - If `start`=1: `sh`←`bin_in`, `acc`←0, `cnt`←WIDTH, go to SHIFT.
  - Otherwise hold all registers.
- SHIFT, every cycle:
  - Adjust: for each digit d of `acc`, d'=d+3 if d≥5, else d' = d.
  - Shift: {`acc`,`sh`} ← {adjusted `acc`, `sh`} shifted left by 1. The MSB of `sh` enters bit 0 of `acc`; the MSB of `acc` is discarded.
  - Decrement `cnt`.
  - When `cnt`=1 before the decrement (the last shift): load `bcd_out` with the shifted `acc` value, set `done`←1, go to IDLE.
- `done` is 0 in every cycle except the one following the last-shift edge.
- `start` while in SHIFT is ignored. No queueing; `bin_in` changes have no effect.
- `start` in the same cycle that `done`=1 is accepted, because the state is already IDLE. This gives back-to-back conversions every WIDTH+1 cycles.
- Arithmetic: each digit stays within 0–9 after every shift. The adjust never carries between digits, so per-digit adders are 4 bits wide.
- Reset (`resetn`=0 at any edge, including mid-conversion):
  - state←IDLE, `busy`=0, `done`=0, `bcd_out`=0, `sh`=0, `acc`=0, `cnt`=0.
  - The aborted conversion produces no `done`.

## Timing
- Let E0 be the edge at which `start` is accepted.
- `busy` is high in the cycles after edges E0 … E(WIDTH−1); that is WIDTH cycles.
- The last shift happens at edge E(WIDTH). After that edge: `busy`=0, `done`=1, and `bcd_out` is valid.
- Latency, start-accept edge to `done` high: WIDTH edges. For the defaults, `done` is high in the 9th cycle counted from the cycle in which `start` was high.
- `bcd_out` changes only at the completion edge or at reset. It is glitch-free for the downstream decoders.
- `busy` and `done` are never high together.

## Structure
- Shared package `display_pkg`:
  - state encoding constants `ST_IDLE`=1'b0, `ST_SHIFT`=1'b1.
  - `BCD_ADJ_THRESH`=4'd5, `BCD_ADJ_ADD`=4'd3.
  - a function computing the required digit count from a width, used by the elaboration check.
- One sub-module, `bcd_digit_adjust`: combinational, 4-bit in/out, add-3-if-≥5. It is instantiated DIGITS times through a generate loop. The FSM, counter and shift path stay in the top module.

## Test plan
- Default parameters, `bin_in`=8'd0, pulse `start` → after 8 edges `done` pulses for 1 cycle and `bcd_out`=12'h000; `busy` is high for exactly 8 cycles.
- `bin_in`=255 → `bcd_out`=12'h255; `bin_in`=128 → 12'h128; `bin_in`=99 → 12'h099. Sweep all 0–255 and compare against a reference model: hundreds, tens, units.
- Hold `start` high continuously, with `bin_in` stepping 7, 42, 200 on each accepted edge → results 12'h007, 12'h042, 12'h200. `done` pulses 9 cycles apart with no lost or duplicated result.
- While converting 8'd37, pulse `start` with `bin_in`=8'd250 mid-SHIFT → the request is ignored; `bcd_out`=12'h037 and exactly one `done` pulse.
- Drive `resetn`=0 for 1 cycle at the 4th SHIFT cycle → next cycle `busy`=0, `done`=0, `bcd_out`=0. No `done` pulse follows; a new `start` with 8'd61 yields 12'h061.
- `WIDTH`=16, `DIGITS`=5, `bin_in`=65535 → `bcd_out`=20'h65535 after 16 edges. `WIDTH`=16, `DIGITS`=4 fails elaboration.
